// File: rtl/flash_host_ctrl.sv
// Request/response front end for the single-port flash/MTP macro: one outstanding
// access, registered macro strobes, programming busy time and read timeout.
module flash_host_ctrl #(
    parameter int unsigned Width      = 32,
    parameter int unsigned Depth      = 8192,
    parameter int unsigned ProgCycles = 4,
    parameter int unsigned RdTimeout  = 8,
    localparam int unsigned Aw        = $clog2(Depth),
    localparam int unsigned NB        = Width / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [NB-1:0]     req_be_i,
    input  logic [Width-1:0]  req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [Width-1:0]  rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              flash_cs_o,
    output logic              flash_we_o,
    output logic [Width-1:0]  flash_wmask_o,
    output logic [Aw-1:0]     flash_addr_o,
    output logic [Width-1:0]  flash_wdata_o,
    input  logic [Width-1:0]  flash_dout_i,
    input  logic              flash_dvalid_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD_STB,
        RD_WAIT,
        WR_STB,
        PROG,
        RSP
    } state_e;

    localparam int unsigned CntMax = (RdTimeout > ProgCycles) ? RdTimeout : ProgCycles;
    localparam int unsigned CW     = $clog2(CntMax + 1);
    localparam logic [CW-1:0] RdLast   = CW'(RdTimeout - 2);
    localparam logic [CW-1:0] ProgLast = (ProgCycles > 0) ? CW'(ProgCycles - 1) : '0;
    localparam logic [31:0]   ByteLimit = 32'(Depth * NB);

    state_e           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_cs, w_cs_nxt;
    logic             r_we, w_we_nxt;
    logic [Width-1:0] r_wmask, w_wmask_nxt;
    logic [Aw-1:0]    r_addr, w_addr_nxt;
    logic [Width-1:0] r_wdata, w_wdata_nxt;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic             r_rsp_err, w_rsp_err_nxt;
    logic [Width-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic [Width-1:0] w_be_mask;
    logic             w_addr_err;

    always_comb begin
        w_be_mask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_be_mask[i*8 +: 8] = {8{req_be_i[i]}};
        end
    end

    assign w_addr_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i >= ByteLimit);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cs_nxt        = 1'b0;
        w_we_nxt        = 1'b0;
        w_wmask_nxt     = '0;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;
        unique case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    if (w_addr_err || (req_we_i && (req_be_i == '0))) begin
                        // Rejected or empty-mask requests answer without touching the macro
                        w_state_nxt     = RSP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = w_addr_err;
                        w_rsp_rdata_nxt = '0;
                    end else begin
                        w_addr_nxt = req_addr_i[Aw+1:2];
                        w_cs_nxt   = 1'b1;
                        if (req_we_i) begin
                            w_we_nxt    = 1'b1;
                            w_wmask_nxt = w_be_mask;
                            w_wdata_nxt = req_wdata_i;
                            w_state_nxt = WR_STB;
                        end else begin
                            w_state_nxt = RD_STB;
                        end
                    end
                end
            end
            RD_STB: begin
                w_state_nxt = RD_WAIT;
                w_cnt_nxt   = '0;
            end
            RD_WAIT: begin
                if (flash_dvalid_i) begin
                    w_state_nxt     = RSP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = flash_dout_i;
                end else if (r_cnt >= RdLast) begin
                    w_state_nxt     = RSP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            WR_STB: begin
                w_cnt_nxt = '0;
                if (ProgCycles == 0) begin
                    w_state_nxt     = RSP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_state_nxt = PROG;
                end
            end
            PROG: begin
                if (r_cnt >= ProgLast) begin
                    w_state_nxt     = RSP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_wmask     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cs        <= w_cs_nxt;
            r_we        <= w_we_nxt;
            r_wmask     <= w_wmask_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    // Gated by rst_ni so every output reads 0 while reset is held
    assign req_ready_o   = rst_ni && (r_state == IDLE);
    assign busy_o        = (r_state != IDLE);
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign flash_cs_o    = r_cs;
    assign flash_we_o    = r_we;
    assign flash_wmask_o = r_wmask;
    assign flash_addr_o  = r_addr;
    assign flash_wdata_o = r_wdata;

endmodule

// File: tb/tb_flash_host_ctrl.sv
// Directed bench for flash_host_ctrl against a behavioural single-port macro
// with a 1-cycle registered read and a switch to suppress dvalid.
module tb_flash_host_ctrl;
    localparam int unsigned W  = 32;
    localparam int unsigned D  = 8192;
    localparam int unsigned NB = 4;
    localparam int unsigned AW = 13;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [31:0]   req_addr_i = '0;
    logic [NB-1:0] req_be_i = '0;
    logic [W-1:0]  req_wdata_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [W-1:0]  rsp_rdata_o;
    logic          rsp_err_o;
    logic          busy_o;
    logic          flash_cs_o;
    logic          flash_we_o;
    logic [W-1:0]  flash_wmask_o;
    logic [AW-1:0] flash_addr_o;
    logic [W-1:0]  flash_wdata_o;
    logic [W-1:0]  flash_dout_i;
    logic          flash_dvalid_i;

    logic          kill = 1'b0;
    logic [W-1:0]  mem [0:D-1];

    int n_chk = 0;
    int n_err = 0;

    int            lat, ncs, sat;
    logic          swe, er;
    logic [31:0]   smask, rd;
    logic [AW-1:0] sad;

    always #5 clk_i = ~clk_i;

    flash_host_ctrl #(
        .Width(W),
        .Depth(D),
        .ProgCycles(4),
        .RdTimeout(8)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_we_i(req_we_i),
        .req_addr_i(req_addr_i),
        .req_be_i(req_be_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .busy_o(busy_o),
        .flash_cs_o(flash_cs_o),
        .flash_we_o(flash_we_o),
        .flash_wmask_o(flash_wmask_o),
        .flash_addr_o(flash_addr_o),
        .flash_wdata_o(flash_wdata_o),
        .flash_dout_i(flash_dout_i),
        .flash_dvalid_i(flash_dvalid_i)
    );

    always_ff @(posedge clk_i) begin
        flash_dvalid_i <= flash_cs_o & ~flash_we_o & ~kill;
        if (flash_cs_o && !flash_we_o) flash_dout_i <= mem[flash_addr_o];
        if (flash_cs_o && flash_we_o)
            mem[flash_addr_o] <= (mem[flash_addr_o] & ~flash_wmask_o) | (flash_wdata_o & flash_wmask_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issues one request from IDLE; lat is the cycle (1 = N+1) rsp_valid_o first rose, 0 if never
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [NB-1:0] be,
                           input logic [W-1:0] data, input bit ack,
                           output int o_lat, output int o_ncs, output int o_sat, output logic o_swe,
                           output logic [31:0] o_smask, output logic [AW-1:0] o_sad,
                           output logic [31:0] o_rd, output logic o_er);
        o_lat = 0; o_ncs = 0; o_sat = 0; o_swe = 1'b0; o_smask = '0; o_sad = '0; o_rd = '0; o_er = 1'b0;
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_be_i = be; req_wdata_i = data;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1) req_valid_i = 1'b0;
            if (flash_cs_o) begin
                o_ncs++;
                if (o_sat == 0) begin
                    o_sat = k; o_swe = flash_we_o; o_smask = flash_wmask_o; o_sad = flash_addr_o;
                end
            end
            if (rsp_valid_o) begin
                o_lat = k; o_rd = rsp_rdata_o; o_er = rsp_err_o;
                break;
            end
        end
        if (ack && o_lat != 0) begin
            rsp_ready_i = 1'b1;
            step();
            rsp_ready_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cs", flash_cs_o, 0);
        chk("rst_we", flash_we_o, 0);
        chk("rst_wmask", flash_wmask_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", req_ready_o, 0);
        rst_ni = 1'b1;
        step();
        chk("post_rst_ready", req_ready_o, 1);
        chk("post_rst_busy", busy_o, 0);

        run_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("wr_lat", lat, 6);
        chk("wr_ncs", ncs, 1);
        chk("wr_stb_at", sat, 1);
        chk("wr_stb_we", swe, 1);
        chk("wr_mask", smask, 32'hFFFFFFFF);
        chk("wr_addr", sad, 4);
        chk("wr_err", er, 0);
        chk("wr_rdata", rd, 0);
        chk("wr_hs_valid", rsp_valid_o, 0);
        chk("wr_hs_ready", req_ready_o, 1);

        run_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("rd_lat", lat, 3);
        chk("rd_ncs", ncs, 1);
        chk("rd_stb_we", swe, 0);
        chk("rd_mask", smask, 0);
        chk("rd_addr", sad, 4);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", er, 0);
        chk("rd_hs_rdata", rsp_rdata_o, 0);

        run_req(1'b1, 32'h20, 4'hF, 32'hAABBCCDD, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("wr2_lat", lat, 6);
        run_req(1'b1, 32'h20, 4'b0101, 32'h11223344, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("pwr_mask", smask, 32'h00FF00FF);
        chk("pwr_addr", sad, 8);
        chk("pwr_lat", lat, 6);
        run_req(1'b0, 32'h20, 4'h0, 32'h0, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("pwr_readback", rd, 32'hAA22CC44);

        run_req(1'b0, 32'h2, 4'h0, 32'h0, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("mis_lat", lat, 1);
        chk("mis_ncs", ncs, 0);
        chk("mis_err", er, 1);
        chk("mis_rdata", rd, 0);
        run_req(1'b0, 32'h8000, 4'h0, 32'h0, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("oob_lat", lat, 1);
        chk("oob_ncs", ncs, 0);
        chk("oob_err", er, 1);
        run_req(1'b0, 32'h7FFC, 4'h0, 32'h0, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("top_lat", lat, 3);
        chk("top_err", er, 0);
        chk("top_addr", sad, 13'h1FFF);

        run_req(1'b1, 32'h30, 4'h0, 32'h12345678, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("be0_lat", lat, 1);
        chk("be0_ncs", ncs, 0);
        chk("be0_err", er, 0);

        run_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("hold_lat", lat, 3);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h20;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", rsp_valid_o, 1);
            chk("hold_rdata", rsp_rdata_o, 32'hDEADBEEF);
            chk("hold_err", rsp_err_o, 0);
            chk("hold_ready", req_ready_o, 0);
            chk("hold_cs", flash_cs_o, 0);
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("hs_valid", rsp_valid_o, 0);
        chk("hs_rdata", rsp_rdata_o, 0);
        chk("hs_ready", req_ready_o, 1);
        step();
        req_valid_i = 1'b0;
        chk("next_cs", flash_cs_o, 1);
        chk("next_addr", flash_addr_o, 8);
        step();
        step();
        chk("next_valid", rsp_valid_o, 1);
        chk("next_rdata", rsp_rdata_o, 32'hAA22CC44);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        kill = 1'b1;
        run_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        kill = 1'b0;
        chk("to_lat", lat, 9);
        chk("to_ncs", ncs, 1);
        chk("to_err", er, 1);
        chk("to_rdata", rd, 0);

        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h40; req_be_i = 4'hF; req_wdata_i = 32'h55;
        step();
        req_valid_i = 1'b0;
        chk("rstb_cs_pre", flash_cs_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rstb_cs", flash_cs_o, 0);
        chk("rstb_we", flash_we_o, 0);
        chk("rstb_wmask", flash_wmask_o, 0);
        chk("rstb_busy", busy_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        chk("rstb_rel_ready", req_ready_o, 1);
        chk("rstb_rel_valid", rsp_valid_o, 0);

        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h40; req_be_i = 4'hF; req_wdata_i = 32'h66;
        step();
        req_valid_i = 1'b0;
        step();
        step();
        chk("rstp_busy_pre", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rstp_busy", busy_o, 0);
        chk("rstp_ready", req_ready_o, 0);
        chk("rstp_cs", flash_cs_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        chk("rstp_rel_busy", busy_o, 0);
        chk("rstp_rel_ready", req_ready_o, 1);
        chk("rstp_rel_valid", rsp_valid_o, 0);

        run_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("rstr_valid_pre", rsp_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rstr_valid", rsp_valid_o, 0);
        chk("rstr_rdata", rsp_rdata_o, 0);
        chk("rstr_busy", busy_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        chk("rstr_rel_valid", rsp_valid_o, 0);
        chk("rstr_rel_ready", req_ready_o, 1);

        run_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b1, lat, ncs, sat, swe, smask, sad, rd, er);
        chk("final_lat", lat, 3);
        chk("final_rdata", rd, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
